// File: rtl/miss_fill_cntl.sv
// miss_fill_cntl: data-cache miss/fill sequencer.
//
// Tracks one outstanding miss (cacheable N-beat fill or noncacheable single beat)
// from request through fill. Also sequences zeroline (allocate-and-zero) fills.
// Provides a critical-word-first beat index and an ack-wait timeout.
//
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   dcu_miss_c          - C-stage miss; smu_na_st_c / req_outstanding / zeroline_c suppress start
//   zeroline_c          - zeroline request; repl_start delays it by one cycle
//   nc_xaction          - current transaction is noncacheable
//   normal_ack          - memory data ack; error_ack - memory error ack
//   miss_word_off       - missed word offset, latched at miss start
//   dc_req / miss_wait  - waiting for first ack
//   miss_idle / dc_idle - miss FSM idle / both FSMs idle
//   first/last_fill_cyc, fill_cyc_active, dc_wr_early, fill_beat_idx - RAM write controls
//   zeroline_busy / zeroline_cyc - zeroline FSM status / zero write active
//   nc_done, dc_error, timeout_err - completion and error status
module miss_fill_cntl #(
    parameter int unsigned FILL_BEATS  = 4,
    parameter int unsigned IDX_W       = 2,
    parameter bit          CWF         = 1'b1,
    parameter int unsigned TO_W        = 8,
    parameter int unsigned TIMEOUT_CYC = 200
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dcu_miss_c,
    input  logic             smu_na_st_c,
    input  logic             zeroline_c,
    input  logic             nc_xaction,
    input  logic             req_outstanding,
    input  logic             repl_start,
    input  logic             normal_ack,
    input  logic             error_ack,
    input  logic [IDX_W-1:0] miss_word_off,
    output logic             dc_req,
    output logic             miss_wait,
    output logic             miss_idle,
    output logic             dc_idle,
    output logic             first_fill_cyc,
    output logic             last_fill_cyc,
    output logic             fill_cyc_active,
    output logic             dc_wr_early,
    output logic [IDX_W-1:0] fill_beat_idx,
    output logic             zeroline_busy,
    output logic             zeroline_cyc,
    output logic             nc_done,
    output logic             dc_error,
    output logic             timeout_err
);

    localparam logic [IDX_W-1:0] LastBeat = IDX_W'(FILL_BEATS - 1);
    localparam bit               ToEn     = (TIMEOUT_CYC != 0);
    localparam logic [TO_W-1:0]  ToLast   = ToEn ? TO_W'(TIMEOUT_CYC - 1) : '0;
    localparam logic [TO_W-1:0]  ToMax    = '1;

    typedef enum logic [3:0] {
        MsIdle  = 4'b0001,
        MsReq   = 4'b0010,
        MsFill  = 4'b0100,
        MsError = 4'b1000
    } miss_state_e;

    typedef enum logic [1:0] {
        ZlIdle,
        ZlWait,
        ZlFill
    } zl_state_e;

    miss_state_e      miss_q, miss_d;
    zl_state_e        zl_q, zl_d;
    logic [IDX_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [IDX_W-1:0] woff_q, woff_d;
    logic [IDX_W-1:0] zcnt_q, zcnt_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;

    logic in_req, in_fill, in_zfill, ack_any, timeout, miss_start;
    logic beat_last, zcnt_last, mfill, mlast;

    always_ff @(posedge clk) begin
        if (reset) begin
            miss_q     <= MsIdle;
            zl_q       <= ZlIdle;
            beat_cnt_q <= '0;
            woff_q     <= '0;
            zcnt_q     <= '0;
            to_cnt_q   <= '0;
        end else begin
            miss_q     <= miss_d;
            zl_q       <= zl_d;
            beat_cnt_q <= beat_cnt_d;
            woff_q     <= woff_d;
            zcnt_q     <= zcnt_d;
            to_cnt_q   <= to_cnt_d;
        end
    end

    always_comb begin
        in_req     = (miss_q == MsReq);
        in_fill    = (miss_q == MsFill);
        in_zfill   = (zl_q == ZlFill);
        ack_any    = normal_ack | error_ack;
        beat_last  = (beat_cnt_q == LastBeat);
        zcnt_last  = (zcnt_q == LastBeat);
        timeout    = ToEn && (in_req || in_fill) && !ack_any && (to_cnt_q == ToLast);
        miss_start = dcu_miss_c && !zeroline_c && !smu_na_st_c && !req_outstanding
                     && (zl_q == ZlIdle);
        mfill      = ((in_req && !nc_xaction) || in_fill) && normal_ack;
        mlast      = in_fill && normal_ack && beat_last;
    end

    // Miss FSM next state
    always_comb begin
        miss_d     = miss_q;
        beat_cnt_d = beat_cnt_q;
        woff_d     = woff_q;
        to_cnt_d   = to_cnt_q;
        unique case (miss_q)
            MsIdle: begin
                if (miss_start) begin
                    miss_d     = MsReq;
                    woff_d     = miss_word_off;
                    beat_cnt_d = '0;
                    to_cnt_d   = '0;
                end
            end
            MsReq, MsFill: begin
                // Wait counter saturates rather than wrapping.
                if (ack_any) begin
                    to_cnt_d = '0;
                end else if (to_cnt_q != ToMax) begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
                if (in_req && normal_ack && nc_xaction) begin
                    miss_d = MsIdle;
                end else if (in_req && normal_ack) begin
                    miss_d     = MsFill;
                    beat_cnt_d = IDX_W'(1);
                end else if (normal_ack && beat_last) begin
                    miss_d = MsIdle;
                end else if (normal_ack) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end else if (error_ack || timeout) begin
                    miss_d = MsError;
                end
            end
            MsError: miss_d = MsIdle;
            default: miss_d = MsIdle;
        endcase
    end

    // Zeroline FSM next state
    always_comb begin
        zl_d   = zl_q;
        zcnt_d = zcnt_q;
        unique case (zl_q)
            ZlIdle: begin
                if (zeroline_c) begin
                    zl_d   = repl_start ? ZlWait : ZlFill;
                    zcnt_d = '0;
                end
            end
            ZlWait: begin
                zl_d   = ZlFill;
                zcnt_d = '0;
            end
            ZlFill: begin
                if (zcnt_last) begin
                    zl_d   = ZlIdle;
                    zcnt_d = '0;
                end else begin
                    zcnt_d = zcnt_q + 1'b1;
                end
            end
            default: zl_d = ZlIdle;
        endcase
    end

    always_comb begin
        dc_req          = in_req;
        miss_wait       = in_req;
        miss_idle       = (miss_q == MsIdle);
        dc_idle         = (miss_q == MsIdle) && (zl_q == ZlIdle);
        zeroline_busy   = (zl_q != ZlIdle);
        zeroline_cyc    = in_zfill;
        dc_error        = (miss_q == MsError);
        timeout_err     = timeout;
        nc_done         = in_req && normal_ack && nc_xaction;
        first_fill_cyc  = (in_req && ack_any) || (in_zfill && (zcnt_q == '0));
        fill_cyc_active = ((in_req || in_fill) && ack_any) || in_zfill;
        last_fill_cyc   = mlast || (in_zfill && zcnt_last);
        dc_wr_early     = (mfill && !mlast) || (in_zfill && !zcnt_last);
        // Zero fills never overlap miss acks, so the zeroline index takes precedence.
        if (in_zfill) begin
            fill_beat_idx = zcnt_q;
        end else if (in_req || in_fill) begin
            fill_beat_idx = CWF ? (woff_q + beat_cnt_q) : beat_cnt_q;
        end else begin
            fill_beat_idx = '0;
        end
    end

endmodule

// File: tb/tb_miss_fill_cntl.sv
module tb_miss_fill_cntl;

    localparam int FB   = 4;
    localparam int IW   = 2;
    localparam int CWFP = 1;
    localparam int TOW  = 4;
    localparam int TOC  = 5;

    typedef struct packed {
        logic          dc_req;
        logic          miss_wait;
        logic          miss_idle;
        logic          dc_idle;
        logic          first;
        logic          last;
        logic          active;
        logic          early;
        logic [IW-1:0] idx;
        logic          zbusy;
        logic          zcyc;
        logic          nc_done;
        logic          dc_error;
        logic          to_err;
    } exp_t;

    logic clk = 1'b0;
    logic reset, dcu_miss_c, smu_na_st_c, zeroline_c, nc_xaction, req_outstanding;
    logic repl_start, normal_ack, error_ack;
    logic [IW-1:0] miss_word_off;
    logic dc_req, miss_wait, miss_idle, dc_idle, first_fill_cyc, last_fill_cyc;
    logic fill_cyc_active, dc_wr_early, zeroline_busy, zeroline_cyc, nc_done;
    logic dc_error, timeout_err;
    logic [IW-1:0] fill_beat_idx;

    int tests = 0;
    int failed = 0;
    int cyc = 0;
    exp_t exp_q[$];

    // Reference model: miss phase 0=idle 1=awaiting first ack 2=filling 3=error;
    // zeroline phase 0=idle 1=waiting for replacement 2=zeroing.
    int m_phase, m_beats, m_wait, m_woff, z_phase, z_beats;

    always #5 clk = ~clk;

    miss_fill_cntl #(
        .FILL_BEATS (FB),
        .IDX_W      (IW),
        .CWF        (CWFP[0]),
        .TO_W       (TOW),
        .TIMEOUT_CYC(TOC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .dcu_miss_c     (dcu_miss_c),
        .smu_na_st_c    (smu_na_st_c),
        .zeroline_c     (zeroline_c),
        .nc_xaction     (nc_xaction),
        .req_outstanding(req_outstanding),
        .repl_start     (repl_start),
        .normal_ack     (normal_ack),
        .error_ack      (error_ack),
        .miss_word_off  (miss_word_off),
        .dc_req         (dc_req),
        .miss_wait      (miss_wait),
        .miss_idle      (miss_idle),
        .dc_idle        (dc_idle),
        .first_fill_cyc (first_fill_cyc),
        .last_fill_cyc  (last_fill_cyc),
        .fill_cyc_active(fill_cyc_active),
        .dc_wr_early    (dc_wr_early),
        .fill_beat_idx  (fill_beat_idx),
        .zeroline_busy  (zeroline_busy),
        .zeroline_cyc   (zeroline_cyc),
        .nc_done        (nc_done),
        .dc_error       (dc_error),
        .timeout_err    (timeout_err)
    );

    task automatic model_reset();
        m_phase = 0; m_beats = 0; m_wait = 0; m_woff = 0; z_phase = 0; z_beats = 0;
    endtask

    // One cycle: drive inputs, predict this cycle's outputs, advance the model.
    task automatic step(input bit rst, input bit miss, input bit nast, input bit zl,
                        input bit nc, input bit rqo, input bit repl, input bit na_in,
                        input bit ea_in, input int woff);
        exp_t e;
        bit na, ea, acked, busy, tmo, wrote_last, mline;
        int idx;
        // No memory acks may arrive while zeroing.
        na = na_in && (z_phase != 2);
        ea = ea_in && (z_phase != 2);
        reset = rst; dcu_miss_c = miss; smu_na_st_c = nast; zeroline_c = zl;
        nc_xaction = nc; req_outstanding = rqo; repl_start = repl;
        normal_ack = na; error_ack = ea; miss_word_off = IW'(woff);

        acked = na || ea;
        busy = (m_phase == 1) || (m_phase == 2);
        tmo = busy && !acked && (TOC > 0) && (m_wait == TOC - 1);
        wrote_last = (m_phase == 2) && na && (m_beats == FB - 1);
        mline = ((m_phase == 1 && !nc) || m_phase == 2) && na;
        if (z_phase == 2) idx = z_beats;
        else if (busy) idx = CWFP != 0 ? (m_woff + m_beats) % FB : m_beats;
        else idx = 0;
        e.dc_req    = (m_phase == 1);
        e.miss_wait = (m_phase == 1);
        e.miss_idle = (m_phase == 0);
        e.dc_idle   = (m_phase == 0) && (z_phase == 0);
        e.first     = (m_phase == 1 && acked) || (z_phase == 2 && z_beats == 0);
        e.last      = wrote_last || (z_phase == 2 && z_beats == FB - 1);
        e.active    = (busy && acked) || (z_phase == 2);
        e.early     = (mline && !wrote_last) || (z_phase == 2 && z_beats != FB - 1);
        e.idx       = IW'(idx);
        e.zbusy     = (z_phase != 0);
        e.zcyc      = (z_phase == 2);
        e.nc_done   = (m_phase == 1) && na && nc;
        e.dc_error  = (m_phase == 3);
        e.to_err    = tmo;
        exp_q.push_back(e);

        if (rst) begin
            model_reset();
        end else begin
            case (m_phase)
                0: if (miss && !zl && !nast && !rqo && z_phase == 0) begin
                    m_phase = 1; m_beats = 0; m_wait = 0; m_woff = woff;
                end
                1, 2: begin
                    if (m_phase == 1 && na && nc) m_phase = 0;
                    else if (m_phase == 1 && na) begin m_phase = 2; m_beats = 1; end
                    else if (na && m_beats == FB - 1) m_phase = 0;
                    else if (na) m_beats++;
                    else if (ea || tmo) m_phase = 3;
                    if (acked) m_wait = 0;
                    else if (m_wait < (1 << TOW) - 1) m_wait++;
                end
                default: m_phase = 0;
            endcase
            case (z_phase)
                0: if (zl) begin z_phase = repl ? 1 : 2; z_beats = 0; end
                1: begin z_phase = 2; z_beats = 0; end
                default: if (z_beats == FB - 1) z_phase = 0; else z_beats++;
            endcase
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_step();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: compares every presented cycle against the next queued prediction.
    initial begin
        exp_t e, got;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                got = '{dc_req, miss_wait, miss_idle, dc_idle, first_fill_cyc, last_fill_cyc,
                        fill_cyc_active, dc_wr_early, fill_beat_idx, zeroline_busy,
                        zeroline_cyc, nc_done, dc_error, timeout_err};
                tests++;
                if (got !== e) begin
                    failed++;
                    $display("FAIL outputs cyc=%0d got=%b expected=%b (req,wait,midle,dcidle,first,last,active,early,idx,zbusy,zcyc,nc,err,to)",
                             cyc, got, e);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; dcu_miss_c = 0; smu_na_st_c = 0; zeroline_c = 0; nc_xaction = 0;
        req_outstanding = 0; repl_start = 0; normal_ack = 0; error_ack = 0; miss_word_off = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        // Reset state with quiet inputs.
        idle_step();
        // Cacheable miss at word 2, four back-to-back acks.
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 2);
        repeat (4) step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        idle_step();
        // Noncacheable single beat.
        step(0, 1, 0, 0, 1, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1, 0, 0, 1, 0, 0);
        idle_step();
        // Error after two beats.
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 3);
        repeat (2) step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        repeat (2) idle_step();
        // Timeout with no ack.
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (8) idle_step();
        // Zeroline behind a replacement; a miss during zeroing must not start.
        step(0, 0, 0, 1, 0, 0, 1, 0, 0, 0);
        repeat (5) step(0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        repeat (3) step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        repeat (3) idle_step();
        // Randomized traffic, including occasional mid-operation resets.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 300) == 0, ($urandom % 3) == 0, ($urandom % 8) == 0,
                 ($urandom % 20) == 0, ($urandom % 4) == 0, ($urandom % 6) == 0,
                 ($urandom % 2) == 0, ($urandom % 10) < 4, ($urandom % 20) == 0,
                 int'($urandom % FB));
        end
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            tests++;
            failed++;
            $display("FAIL drain got=%0d pending expected=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/miss_fill_cntl.md
Name: miss_fill_cntl

Overview:
- Parametrised data-cache miss/fill sequencer, the successor to the fixed 4-beat DCU miss controller.
- Tracks one outstanding cacheable or noncacheable miss from request through N-beat fill.
- Sequences zeroline (allocate-and-zero) fills.
- Adds a critical-word-first beat index, a request/fill timeout, and miss/zeroline mutual exclusion.
- Sits in the DCU between the C-stage miss detect logic, the bus interface ack path and the data RAM write port.

Parameters:
FILL_BEATS, 4, beats per line fill; power of 2, >=2
IDX_W, 2, beat index width; must equal log2(FILL_BEATS)
CWF, 1, 1 = fill_beat_idx starts at the missed word and wraps; 0 = starts at 0
TO_W, 8, timeout counter width
TIMEOUT_CYC, 200, ack-wait limit in cycles; 0 disables the timeout

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
dcu_miss_c  in  1  cache miss in C stage
smu_na_st_c  in  1  non-allocating store; suppresses miss start
zeroline_c  in  1  zeroline instruction in C stage
nc_xaction  in  1  current transaction is noncacheable
req_outstanding  in  1  memory request already outstanding; blocks miss start
repl_start  in  1  dirty-line replacement pending
normal_ack  in  1  memory ack; data valid this cycle
error_ack  in  1  memory error ack
miss_word_off  in  IDX_W  word offset of the missing access
dc_req  out  1  waiting for first ack
miss_wait  out  1  pipe hold; equals dc_req
miss_idle  out  1  miss FSM idle
dc_idle  out  1  miss FSM and zeroline FSM both idle
first_fill_cyc  out  1  first RAM write of a fill
last_fill_cyc  out  1  last RAM write of a fill
fill_cyc_active  out  1  RAM write this cycle
dc_wr_early  out  1  any fill write except the last
fill_beat_idx  out  IDX_W  word index written this cycle
zeroline_busy  out  1  zeroline FSM not idle
zeroline_cyc  out  1  zeroline fill write active
nc_done  out  1  noncacheable single-beat completion pulse
dc_error  out  1  miss FSM in ERROR state
timeout_err  out  1  one-cycle pulse on timeout entry to ERROR

Behaviour:
- Single clock. Reset is synchronous and active-high.
- Reset values:
  - Both FSMs go to IDLE; beat, timeout and zeroline counters clear to 0.
  - miss_idle=1, dc_idle=1; all other outputs 0; fill_beat_idx=0.
- Miss FSM (one-hot IDLE, REQ, FILL, ERROR):
  - IDLE->REQ when dcu_miss_c & !zeroline_c & !smu_na_st_c & !req_outstanding & zeroline_busy==0. On this transition, latch miss_word_off into woff_q and clear beat_cnt and to_cnt.
  - REQ, priority high to low:
    - normal_ack & nc_xaction -> IDLE, with nc_done=1.
    - normal_ack -> FILL, with beat_cnt=1.
    - error_ack -> ERROR.
    - timeout -> ERROR, with timeout_err=1.
    - otherwise stay in REQ.
  - FILL, priority high to low:
    - normal_ack & beat_cnt==FILL_BEATS-1 -> IDLE.
    - normal_ack -> beat_cnt+1, stay in FILL.
    - error_ack -> ERROR.
    - timeout -> ERROR.
  - ERROR -> IDLE unconditionally after 1 cycle.
  - error_ack in IDLE or ERROR is ignored.
- Timeout:
  - to_cnt increments each REQ/FILL cycle without normal_ack or error_ack, and clears on either ack.
  - Timeout fires when to_cnt==TIMEOUT_CYC-1 and the current cycle has no ack.
  - Never fires when TIMEOUT_CYC==0.
  - to_cnt saturates and does not wrap.
- Zeroline FSM (IDLE, WAIT, ZFILL), with counter zcnt of IDX_W bits:
  - IDLE->ZFILL (zcnt=0) when zeroline_c & !repl_start.
  - IDLE->WAIT when zeroline_c & repl_start.
  - WAIT->ZFILL after 1 cycle.
  - ZFILL increments zcnt each cycle; -> IDLE when zcnt==FILL_BEATS-1, so it is exactly FILL_BEATS cycles.
  - zeroline_c while busy is ignored.
- Output equations, where mfill=(REQ & !nc_xaction | FILL) & normal_ack and mlast=FILL & normal_ack & beat_cnt==FILL_BEATS-1:
  - first_fill_cyc = REQ & (normal_ack|error_ack) | ZFILL & zcnt==0.
  - fill_cyc_active = (REQ|FILL) & (normal_ack|error_ack) | ZFILL. A noncacheable ack also asserts it.
  - last_fill_cyc = mlast | ZFILL & zcnt==FILL_BEATS-1.
  - dc_wr_early = mfill & !mlast | ZFILL & zcnt!=FILL_BEATS-1.
  - zeroline_cyc = ZFILL.
- fill_beat_idx:
  - Miss: CWF ? (woff_q + beat_cnt) mod FILL_BEATS : beat_cnt.
  - Zeroline: zcnt.
  - Otherwise 0.
  - Addition wraps at IDX_W bits.
- Concurrency: miss start is blocked while zeroline_busy. A zeroline may start while the miss FSM is non-idle; upstream guarantees that no acks arrive during ZFILL.
- A synchronous reset mid-fill aborts both FSMs to IDLE on the next edge. No partial-fill completion is signalled.

Test Plan:
- Reset held 2 cycles, then miss with woff=2, 4 acks back-to-back -> dc_req 1 cycle after miss; fill_beat_idx sequence 2,3,0,1; first_fill_cyc on beat 0; last_fill_cyc on beat 3; dc_wr_early on beats 0-2; miss_idle=1 next cycle.
- Noncacheable miss, single ack -> nc_done=1, fill_cyc_active=1, last_fill_cyc=0; IDLE next cycle.
- error_ack after 2 fill beats -> dc_error=1 for exactly 1 cycle, then IDLE; no last_fill_cyc.
- TIMEOUT_CYC=5, no ack -> timeout_err pulses on cycle 5 of REQ; ERROR 1 cycle; IDLE.
- zeroline_c with repl_start=1 -> WAIT 1 cycle, then zeroline_cyc for 4 cycles with idx 0..3; a dcu_miss_c during ZFILL does not assert dc_req.
- FILL_BEATS=8, CWF=0, acks with gaps -> beat_cnt holds across gaps; idx 0..7; last on the 8th ack.
